adc_sample_decimator: RTL and testbench
=======================================

ADC_SAMPLE_DECIMATOR -- requirements
Module: adc_sample_decimator

Interface
REQ-001 The block SHALL have parameter LOG2_N, default 2, log2 of samples averaged per output word (legal 0..4).
REQ-002 The block SHALL have parameter TIMEOUT, default 65535, clocks without sample_valid before the stale state.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  high = decimation running; low = idle.
REQ-006 sample_valid  input  1  one-cycle pulse, sample_in valid this cycle.
REQ-007 sample_in  input  12  unsigned offset-binary ADC code (0x800 = mid-scale).
REQ-008 sample_out  output  16  signed two's-complement audio word, held between updates.
REQ-009 sample_out_valid  output  1  one-cycle pulse when sample_out updates.
REQ-010 stale  output  1  high while the ADC stream has timed out.

Function
REQ-011 The block SHALL implement states IDLE, ACCUM, EMIT: IDLE->ACCUM when enable=1; ACCUM->EMIT on the sample_valid completing 2^LOG2_N samples; EMIT->ACCUM after one cycle; any state->IDLE when enable=0.
REQ-012 In ACCUM each sample_valid SHALL add sample_in to a (12+LOG2_N)-bit sum and increment the window count.
REQ-013 The average SHALL be sum >> LOG2_N (12 bits, truncating); the signed word SHALL be {~avg[11], avg[10:0], 4'b0000}.
REQ-014 sample_out/sample_out_valid SHALL update one cycle after the completing sample_valid (two with the macro).
REQ-015 A sample_valid arriving in the EMIT cycle SHALL start the next window (sum loads sample_in, count=1); no sample is dropped.
REQ-016 sample_valid in IDLE SHALL be ignored.
REQ-017 Deasserting enable mid-window SHALL discard the partial sum; sample_out holds its last value; no valid pulse.
REQ-018 A timeout counter SHALL reset on every sample_valid and saturate; on reaching TIMEOUT while not IDLE, stale=1, sample_out=0x0000, partial window discarded, no valid pulse.
REQ-019 stale SHALL clear on the next completed window, in the same cycle sample_out_valid pulses.
REQ-020 Simultaneous timeout and sample_valid SHALL treat the sample as arrived (no timeout).

Reset
REQ-021 On reset_n low: state=IDLE, sum=0, count=0, timeout counter=0, sample_out=0x0000, sample_out_valid=0, stale=0, DC estimate=0.
REQ-022 Reset mid-window SHALL discard all accumulated state without emitting a pulse.

Configuration
REQ-023 Macro ADC_DC_BLOCK_EN SHALL compile in a DC-blocking stage; without it sample_out equals the REQ-013 word.
REQ-024 With ADC_DC_BLOCK_EN: 26-bit signed estimate d; per emitted word x, y = x - d[25:10] saturated to -32768..32767, then d <= d + (x - d[25:10]); y is output, with one added pipeline cycle.
REQ-025 With ADC_DC_BLOCK_EN, the timeout forced zero SHALL bypass the filter and SHALL NOT update d.

Verification
REQ-026 LOG2_N=2, enable=1, four pulses of 0xFFF -> one cycle after the fourth pulse sample_out=0x7FF0, sample_out_valid=1 for exactly one cycle.
REQ-027 LOG2_N=2, pulses 0x000,0x001,0x002,0x003 -> avg=0x001, sample_out=0x8010.
REQ-028 Fourth pulse followed by a pulse of 0x800 in the EMIT cycle -> first word emitted, next window count=1, three further 0x800 pulses -> sample_out=0x0000.
REQ-029 TIMEOUT=100, two pulses then none for 100 clocks -> stale=1, sample_out=0x0000, no valid pulse; next four pulses -> stale=0 with valid pulse.
REQ-030 Two pulses, enable low one cycle, enable high, four pulses of 0x900 -> single valid pulse, sample_out=0x1000.
REQ-031 ADC_DC_BLOCK_EN defined, constant input 0xC00 -> first output 0x4000, two cycles after window end; output magnitude decays monotonically toward 0.

Source files
------------

// File: rtl/adc_sample_decimator.sv
// adc_sample_decimator
// Averages 2^LOG2_N unsigned offset-binary 12-bit ADC samples into one signed
// 16-bit audio word. A timeout counter flags a stalled ADC stream (stale) and
// forces the output word to zero.
// Optional feature: define ADC_DC_BLOCK_EN to add a DC-blocking stage with one
// extra output pipeline cycle. Without it the output is the plain average word.
module adc_sample_decimator #(
  parameter int LOG2_N  = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [11:0] sample_in,
  output logic [15:0] sample_out,
  output logic        sample_out_valid,
  output logic        stale
);

  localparam int SW = 12 + LOG2_N;
  localparam int CW = LOG2_N + 1;
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] LAST_CNT = CW'((1 << LOG2_N) - 1);
  localparam logic [TW-1:0] TO_FIRE  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_SAT   = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

  // Offset-binary average to signed word: flip the MSB, scale to 16 bits.
  function automatic logic [15:0] to_signed_word(input logic [11:0] avg);
    return {~avg[11], avg[10:0], 4'b0000};
  endfunction

  state_e         state_q, state_d;
  logic [SW-1:0]  sum_q, sum_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  to_q, to_d;
  logic [15:0]    out_q, out_d;
  logic           out_vld_q, out_vld_d;
  logic           stale_q, stale_d;

  logic [SW-1:0]  sum_base_s;
  logic [CW-1:0]  cnt_base_s;
  logic [SW-1:0]  full_sum_s;
  logic [11:0]    avg_s;
  logic           last_s;
  logic           emit_s;
  logic           timeout_s;

`ifdef ADC_DC_BLOCK_EN
  // Saturate a 17-bit signed difference into the 16-bit signed range.
  function automatic logic [15:0] sat16(input logic [16:0] e);
    if (e[16] != e[15]) begin
      return e[16] ? 16'h8000 : 16'h7FFF;
    end else begin
      return e[15:0];
    end
  endfunction

  logic [15:0] x_q, x_d;
  logic        x_vld_q, x_vld_d;
  logic [25:0] dc_q, dc_d;
  logic [16:0] err_s;
`endif

  // Window FSM, accumulator and timeout counter next-state logic
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    emit_s    = 1'b0;
    timeout_s = 1'b0;
    // The EMIT cycle already belongs to the next window, which starts empty.
    if (state_q == ST_EMIT) begin
      sum_base_s = '0;
      cnt_base_s = '0;
    end else begin
      sum_base_s = sum_q;
      cnt_base_s = cnt_q;
    end
    full_sum_s = sum_base_s + SW'(sample_in);
    avg_s      = full_sum_s[SW-1:LOG2_N];
    last_s     = (cnt_base_s == LAST_CNT);
    if (!enable) begin
      state_d = ST_IDLE;
      sum_d   = '0;
      cnt_d   = '0;
      to_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACCUM;
          sum_d   = '0;
          cnt_d   = '0;
          to_d    = '0;
        end
        ST_ACCUM, ST_EMIT: begin
          if (sample_valid) begin
            // A sample arriving on the timeout cycle still counts as arrived.
            to_d = '0;
            if (last_s) begin
              emit_s  = 1'b1;
              state_d = ST_EMIT;
              sum_d   = '0;
              cnt_d   = '0;
            end else begin
              state_d = ST_ACCUM;
              sum_d   = full_sum_s;
              cnt_d   = cnt_base_s + CW'(1);
            end
          end else if (to_q == TO_FIRE) begin
            timeout_s = 1'b1;
            to_d      = TO_SAT;
            state_d   = ST_ACCUM;
            sum_d     = '0;
            cnt_d     = '0;
          end else begin
            state_d = ST_ACCUM;
            sum_d   = sum_base_s;
            cnt_d   = cnt_base_s;
            if (to_q != TO_SAT) begin
              to_d = to_q + TW'(1);
            end else begin
              to_d = to_q;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          sum_d   = '0;
          cnt_d   = '0;
          to_d    = '0;
        end
      endcase
    end
  end

  // Output word, valid pulse and stale flag next-state logic
  always_comb begin
    out_d     = out_q;
    out_vld_d = 1'b0;
    stale_d   = stale_q;
`ifdef ADC_DC_BLOCK_EN
    dc_d    = dc_q;
    x_vld_d = emit_s;
    if (emit_s) begin
      x_d = to_signed_word(avg_s);
    end else begin
      x_d = x_q;
    end
    err_s = {x_q[15], x_q} - {dc_q[25], dc_q[25:10]};
    if (timeout_s) begin
      // Forced zero bypasses the filter; a pending word is dropped.
      out_d   = 16'h0000;
      x_vld_d = 1'b0;
    end else if (x_vld_q) begin
      out_d     = sat16(err_s);
      out_vld_d = 1'b1;
      dc_d      = dc_q + {{9{err_s[16]}}, err_s};
    end else begin
      out_d = out_q;
    end
`else
    if (emit_s) begin
      out_d     = to_signed_word(avg_s);
      out_vld_d = 1'b1;
    end else if (timeout_s) begin
      out_d = 16'h0000;
    end else begin
      out_d = out_q;
    end
`endif
    // stale drops together with the first valid pulse after the timeout.
    if (out_vld_d) begin
      stale_d = 1'b0;
    end else if (timeout_s) begin
      stale_d = 1'b1;
    end else begin
      stale_d = stale_q;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      sum_q     <= '0;
      cnt_q     <= '0;
      to_q      <= '0;
      out_q     <= 16'h0000;
      out_vld_q <= 1'b0;
      stale_q   <= 1'b0;
`ifdef ADC_DC_BLOCK_EN
      x_q       <= 16'h0000;
      x_vld_q   <= 1'b0;
      dc_q      <= 26'd0;
`endif
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      stale_q   <= stale_d;
`ifdef ADC_DC_BLOCK_EN
      x_q       <= x_d;
      x_vld_q   <= x_vld_d;
      dc_q      <= dc_d;
`endif
    end
  end

  assign sample_out       = out_q;
  assign sample_out_valid = out_vld_q;
  assign stale            = stale_q;

endmodule

// File: tb/tb_adc_sample_decimator.sv
// Self-checking bench for adc_sample_decimator (default build, DC block off).
module tb_adc_sample_decimator;

  localparam int LOG2_N  = 2;
  localparam int NWIN    = 1 << LOG2_N;
  localparam int TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        sample_valid;
  logic [11:0] sample_in;
  logic [15:0] sample_out;
  logic        sample_out_valid;
  logic        stale;

  int n_checks = 0;
  int n_pass   = 0;

  adc_sample_decimator #(.LOG2_N(LOG2_N), .TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable           (enable),
    .sample_valid     (sample_valid),
    .sample_in        (sample_in),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid),
    .stale            (stale)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (window of samples as a queue) ----------
  bit          m_active;
  int          m_win[$];
  int          m_gap;
  logic [15:0] m_out;
  bit          m_vld;
  bit          m_stale;

  function automatic logic [15:0] expect_word(input int avg);
    int v;
    v = (avg - 2048) * 16;
    return 16'(v);
  endfunction

  function automatic void model_reset();
    m_active = 1'b0;
    m_win.delete();
    m_gap   = 0;
    m_out   = 16'h0000;
    m_vld   = 1'b0;
    m_stale = 1'b0;
  endfunction

  function automatic void model_step();
    int sum;
    sum   = 0;
    m_vld = 1'b0;
    if (!enable) begin
      m_active = 1'b0;
      m_win.delete();
      m_gap = 0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_gap    = 0;
    end else if (sample_valid) begin
      m_gap = 0;
      m_win.push_back(int'(sample_in));
      if (m_win.size() == NWIN) begin
        foreach (m_win[i]) sum += m_win[i];
        m_out   = expect_word(sum / NWIN);
        m_vld   = 1'b1;
        m_stale = 1'b0;
        m_win.delete();
      end
    end else if (m_gap == TIMEOUT - 1) begin
      m_gap   = TIMEOUT;
      m_stale = 1'b1;
      m_out   = 16'h0000;
      m_win.delete();
    end else if (m_gap < TIMEOUT) begin
      m_gap++;
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic cycle(input logic en, input logic v, input logic [11:0] d);
    enable       = en;
    sample_valid = v;
    sample_in    = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h, want 0x%04h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_all(input string tag, input logic [15:0] eo, input logic ev, input logic es);
    chk({tag, " out"}, sample_out, eo);
    chk({tag, " vld"}, {15'd0, sample_out_valid}, {15'd0, ev});
    chk({tag, " stale"}, {15'd0, stale}, {15'd0, es});
  endtask

  typedef struct {
    logic        en;
    logic        v;
    logic [11:0] din;
    logic [15:0] eout;
    logic        evld;
    logic        estale;
  } vec_t;

  vec_t tbl[$];
  int   pulses;
  int   pct;
  logic r_en;
  logic r_v;

  initial begin
    // Table: windows of 0xFFF, 0..3, back-to-back with EMIT-cycle sample, gapped.
    tbl.push_back('{1'b1, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0}); // IDLE -> ACCUM
    tbl.push_back('{1'b1, 1'b1, 12'hFFF, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 12'hFFF, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 12'hFFF, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 12'hFFF, 16'h7FF0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 12'h000, 16'h7FF0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 12'h000, 16'h7FF0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 12'h001, 16'h7FF0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 12'h002, 16'h7FF0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 12'h003, 16'h8010, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 12'h800, 16'h8010, 1'b0, 1'b0}); // sample in EMIT
    tbl.push_back('{1'b1, 1'b1, 12'h800, 16'h8010, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 12'h800, 16'h8010, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 12'h800, 16'h0000, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 12'h123, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 12'h456, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 12'h789, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 12'hABC, 16'hDEF0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 12'h000, 16'hDEF0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 12'hFFF, 16'hDEF0, 1'b0, 1'b0}); // enable low

    // Reset state
    reset_n      = 1'b0;
    enable       = 1'b0;
    sample_valid = 1'b0;
    sample_in    = 12'h000;
    model_reset();
    #12;
    chk_all("reset", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].en, tbl[i].v, tbl[i].din);
      chk_all($sformatf("vec%0d", i), tbl[i].eout, tbl[i].evld, tbl[i].estale);
    end

    // Enable drop mid-window discards partial sum; IDLE-cycle sample ignored
    pulses = 0;
    cycle(1'b1, 1'b1, 12'hFFF);
    pulses += int'(sample_out_valid);
    cycle(1'b1, 1'b1, 12'h100);
    pulses += int'(sample_out_valid);
    cycle(1'b1, 1'b1, 12'h100);
    pulses += int'(sample_out_valid);
    cycle(1'b0, 1'b0, 12'h000);
    pulses += int'(sample_out_valid);
    cycle(1'b1, 1'b0, 12'h000);
    pulses += int'(sample_out_valid);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 12'h900);
      pulses += int'(sample_out_valid);
    end
    chk("drop out", sample_out, 16'h1000);
    cycle(1'b1, 1'b0, 12'h000);
    pulses += int'(sample_out_valid);
    chk("drop pulses", 16'(pulses), 16'd1);

    // Timeout: two pulses, then silence
    cycle(1'b1, 1'b1, 12'h200);
    cycle(1'b1, 1'b1, 12'h200);
    pulses = 0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      cycle(1'b1, 1'b0, 12'h000);
      pulses += int'(sample_out_valid);
    end
    chk("to before stale", {15'd0, stale}, 16'd0);
    cycle(1'b1, 1'b0, 12'h000);
    pulses += int'(sample_out_valid);
    chk_all("to fire", 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 12'h000);
      pulses += int'(sample_out_valid);
    end
    chk("to no pulse", 16'(pulses), 16'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 12'hC00);
      chk_all($sformatf("to win%0d", i), 16'h0000, 1'b0, 1'b1);
    end
    cycle(1'b1, 1'b1, 12'hC00);
    chk_all("to recover", 16'h4000, 1'b1, 1'b0);

    // Sample coincident with timeout counts as arrived
    cycle(1'b1, 1'b1, 12'h300);
    for (int i = 0; i < TIMEOUT - 1; i++) cycle(1'b1, 1'b0, 12'h000);
    cycle(1'b1, 1'b1, 12'h300);
    chk("coinc stale", {15'd0, stale}, 16'd0);
    for (int i = 0; i < 50; i++) cycle(1'b1, 1'b0, 12'h000);
    chk("coinc stale2", {15'd0, stale}, 16'd0);
    cycle(1'b1, 1'b1, 12'h300);
    cycle(1'b1, 1'b1, 12'h300);
    chk_all("coinc word", 16'hB000, 1'b1, 1'b0);

    // Reset mid-window discards the partial window
    cycle(1'b1, 1'b1, 12'h7FF);
    cycle(1'b1, 1'b1, 12'h7FF);
    enable       = 1'b0;
    sample_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("rst mid", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    cycle(1'b1, 1'b0, 12'h000);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 12'h400);
      chk($sformatf("rst win%0d vld", i), {15'd0, sample_out_valid}, 16'd0);
    end
    cycle(1'b1, 1'b1, 12'h400);
    chk_all("rst word", 16'hC000, 1'b1, 1'b0);

    // Randomized stimulus against the reference model
    for (int seg = 0; seg < 12; seg++) begin
      case (seg % 4)
        0:       pct = 100;
        1:       pct = 40;
        2:       pct = 1;
        default: pct = 20;
      endcase
      for (int c = 0; c < 250; c++) begin
        r_en = ($urandom_range(0, 99) != 0);
        r_v  = ($urandom_range(1, 100) <= pct);
        cycle(r_en, r_v, 12'($urandom_range(0, 4095)));
        chk_all("rand", m_out, m_vld, m_stale);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
